mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Processor-side requester (initiator) for the word-addressed data memory.
- Accepts byte-addressed load/store requests from the datapath with a valid/ready handshake.
- Drives the memory's addr/write_data/MemRead/MemWrite pins and returns extracted, extended load data.
- Implements byte and halfword stores as read-modify-write on the 32-bit word array; rejects misaligned and out-of-range accesses.

Parameters:
MEM_DEPTH, 64, number of 32-bit words in the attached memory; word index >= MEM_DEPTH is an error.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result (0 for stores and errors)
resp_error  output  1  qualifies resp_valid; misaligned, illegal size or out of range
mem_addr  output  32  word index = req_addr >> 2
mem_write_data  output  32  word to write
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
mem_read_data  input  32  combinational memory read data

Behaviour:
- Reset (rst low, any state): state to IDLE; every output 0, including req_ready. Captured request and data registers cleared. An in-flight access is abandoned; no MemWrite is issued after reset.
- Memory contract: read data is combinational from mem_addr. A write commits on the rising edge while MemWrite=1.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. Accept on the rising edge when req_valid=1; latch write, size, unsigned, addr and wdata.
  - Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]!=0; (addr>>2) >= MEM_DEPTH. Error -> RESP with error flag set; no memory strobe is ever asserted.
  - Otherwise: load -> RD; word store -> WR; byte/half store -> RD.
- RD: MemRead=1, mem_addr=latched word index. Capture mem_read_data on the edge. Load -> RESP; sub-word store -> WR.
- WR: MemWrite=1, mem_addr=word index, mem_write_data = merged word. Next state RESP.
  - Word store: merged word = wdata.
  - Byte store: captured word with lane addr[1:0] (bits 8*lane+7:8*lane) replaced by wdata[7:0].
  - Half store: lane addr[1] (bits 16*addr[1]+15:16*addr[1]) replaced by wdata[15:0].
- RESP: resp_valid=1 for exactly one cycle; resp_error per latched flag.
  - resp_rdata for loads: selected lane, sign- or zero-extended per unsigned (word loads unaffected).
  - resp_rdata = 0 for stores and errors.
  - Next state IDLE.
- Lanes are little-endian.
- Outside their states, MemRead, MemWrite, mem_addr and mem_write_data are 0.
- Latency, accept edge to resp_valid cycle:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Throughput: one request in flight. req_ready=0 in RD/WR/RESP, so a new request can be accepted only in the IDLE cycle after RESP.
- req_* inputs are ignored when not accepted. Changes to req_* after accept have no effect.
- MemRead and MemWrite are never asserted in the same cycle.

Test Plan:
- After reset release, load word at req_addr=0x14 -> RD cycle with MemRead=1, mem_addr=5; next cycle resp_valid=1, resp_rdata=0x00000007, resp_error=0. Check reset values of all outputs while rst=0.
- Byte store 0xFF at 0x29 -> RD then WR with mem_addr=10, mem_write_data=0x0000FF0A. Then signed byte load at 0x29 returns 0xFFFFFFFF; unsigned byte load returns 0x000000FF.
- Half store 0x8001 at 0x32 -> WR writes 0x8001000C to word 12. Then signed half load at 0x32 returns 0xFFFF8001; unsigned half load returns 0x00008001.
- Word load at 0x06, half load at 0x03, size 11, and word load at 0x100 -> each gives resp_valid with resp_error=1 one cycle after accept, rdata=0, and MemRead/MemWrite stay 0.
- Word store 0xDEADBEEF at 0x08 -> a single MemWrite cycle with mem_addr=2. A following load at 0x08 returns 0xDEADBEEF. req_ready is low from accept through RESP; back-to-back req_valid is accepted only after RESP.
- Assert rst during the RD cycle of a byte store -> MemWrite never pulses, outputs go to 0, and after release req_ready=1 and a fresh load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store requester for a word-addressed data memory; sub-word stores are read-modify-write.
// Latency accept->resp: error 1, load 2, word store 2, sub-word store 3; req_ready low while a request is in flight.
module mem_access_unit #(
  parameter int MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;
  logic        bad_req;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*lane +: 8];
    h = word[16*lane[1] +: 16];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                        input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    case (size)
      2'b00:   m[8*lane +: 8] = wdata[7:0];
      2'b01:   m[16*lane[1] +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign bad_req = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                   ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH));

  // Outputs are registered, so each branch sets the values seen in the state being entered.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d    = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (bad_req) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (req_write && req_size == 2'b10) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_addr_d  = {2'b00, req_addr[31:2]};
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
            mem_addr_d = {2'b00, req_addr[31:2]};
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      RD: begin
        if (wr_q) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          mem_addr_d  = {2'b00, addr_q[31:2]};
          mem_wdata_d = merge(mem_read_data, wdata_q, size_q, addr_q[1:0]);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = extract(mem_read_data, size_q, addr_q[1:0], uns_q);
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign MemRead        = mem_read_q;
  assign MemWrite       = mem_write_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: attached word memory plus a byte-level reference model of load/store results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_read_data;

  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];
  logic [31:0] last_rdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_access_unit #(.MEM_DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Attached memory: combinational read, write on the rising edge with MemWrite.
  assign mem_read_data = (mem_addr < 32'd64) ? mem_arr[mem_addr[5:0]] : 32'h0;
  always @(posedge clk) if (MemWrite && mem_addr < 32'd64) mem_arr[mem_addr[5:0]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_nz();
    return 32'({req_ready, resp_valid, |resp_rdata, resp_error, |mem_addr, |mem_write_data, MemRead, MemWrite});
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    int          cyc, exp_lat, rd_cnt, wr_cnt, exp_rd, exp_wr, lane;
    logic        err, both, rdy_seen, got_resp, got_err, bus_dirty;
    logic [31:0] idx, rd_a, wr_a, wr_d, got_rdata, old, v, exp_data, merged;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // Keep valid high with junk fields while busy: none of it may be taken.
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    rd_cnt = 0; wr_cnt = 0; both = 0; rdy_seen = 0; got_resp = 0; got_err = 0;
    bus_dirty = 0; rd_a = '0; wr_a = '0; wr_d = '0; got_rdata = '0; cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      cyc = i;
      if (MemRead) begin rd_cnt++; rd_a = mem_addr; end
      if (MemWrite) begin wr_cnt++; wr_a = mem_addr; wr_d = mem_write_data; end
      if (MemRead && MemWrite) both = 1;
      if (req_ready) rdy_seen = 1;
      if (resp_valid) begin
        got_resp = 1; got_err = resp_error; got_rdata = resp_rdata;
        bus_dirty = MemRead | MemWrite | (|mem_addr) | (|mem_write_data);
        break;
      end
    end
    req_valid = 1'b0;
    last_rdata = got_rdata;

    idx  = a >> 2;
    lane = int'(a[1:0]);
    err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (idx >= 64);
    exp_lat = err ? 1 : (!w ? 2 : (sz == 2'd2 ? 2 : 3));
    exp_rd  = (!err && (!w || sz != 2'd2)) ? 1 : 0;
    exp_wr  = (!err && w) ? 1 : 0;
    exp_data = 32'h0;
    merged = 32'h0;
    if (!err) begin
      old = ref_mem[idx[5:0]];
      if (!w) begin
        if (sz == 2'd0) begin
          v = (old >> (8 * lane)) & 32'hFF;
          exp_data = (!u && v[7]) ? (v | 32'hFFFFFF00) : v;
        end else if (sz == 2'd1) begin
          v = (old >> (16 * (lane / 2))) & 32'hFFFF;
          exp_data = (!u && v[15]) ? (v | 32'hFFFF0000) : v;
        end else begin
          exp_data = old;
        end
      end else begin
        if (sz == 2'd0)
          merged = (old & ~(32'hFF << (8 * lane))) | ((wd & 32'hFF) << (8 * lane));
        else if (sz == 2'd1)
          merged = (old & ~(32'hFFFF << (16 * (lane / 2)))) | ((wd & 32'hFFFF) << (16 * (lane / 2)));
        else
          merged = wd;
        ref_mem[idx[5:0]] = merged;
      end
    end

    check("resp_seen", 32'(got_resp), 32'd1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("resp_error", 32'(got_err), 32'(err));
    check("resp_rdata", got_rdata, exp_data);
    check("memread_cycles", 32'(rd_cnt), 32'(exp_rd));
    check("memwrite_cycles", 32'(wr_cnt), 32'(exp_wr));
    check("rw_exclusive", 32'(both), 32'd0);
    check("ready_low_busy", 32'(rdy_seen), 32'd0);
    check("bus_idle_in_resp", 32'(bus_dirty), 32'd0);
    if (exp_rd == 1) check("rd_addr", rd_a, idx);
    if (exp_wr == 1) begin
      check("wr_addr", wr_a, idx);
      check("wr_data", wr_d, merged);
    end
    @(negedge clk);
    check("resp_pulse_ready", 32'({resp_valid, req_ready}), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = 32'(i);
      ref_mem[i] = 32'(i);
    end
    mem_arr[5] = 32'h7;
    ref_mem[5] = 32'h7;
    last_rdata = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", outs_nz(), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    check("ld_word5", last_rdata, 32'h7);

    do_req(1'b1, 2'd0, 1'b0, 32'h29, 32'hFF);
    check("bst_mem10", mem_arr[10], 32'h0000FF0A);
    do_req(1'b0, 2'd0, 1'b0, 32'h29, 32'h0);
    check("ld_sbyte", last_rdata, 32'hFFFFFFFF);
    do_req(1'b0, 2'd0, 1'b1, 32'h29, 32'h0);
    check("ld_ubyte", last_rdata, 32'h000000FF);

    do_req(1'b1, 2'd1, 1'b0, 32'h32, 32'h8001);
    check("hst_mem12", mem_arr[12], 32'h8001000C);
    do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'h0);
    check("ld_shalf", last_rdata, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b1, 32'h32, 32'h0);
    check("ld_uhalf", last_rdata, 32'h00008001);

    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h03, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h100, 32'h5A);

    do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF);
    check("wst_mem2", mem_arr[2], 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    check("ld_deadbeef", last_rdata, 32'hDEADBEEF);

    // Reset while the read half of a byte store is in progress.
    begin
      logic wr_seen;
      wr_seen = 0;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h21; req_wdata = 32'h77;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_memread", 32'(MemRead), 32'd1);
      rst = 1'b0;
      #1;
      check("rst_mid_outputs", outs_nz(), 32'd0);
      repeat (3) begin
        @(negedge clk);
        if (MemWrite) wr_seen = 1;
      end
      check("rst_no_memwrite", 32'(wr_seen), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_release_ready", 32'(req_ready), 32'd1);
      check("rst_mem8_intact", mem_arr[8], 32'h8);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    check("ld_after_rst", last_rdata, 32'h8);

    for (int t = 0; t < 250; t++) begin
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             32'($urandom_range(0, 300)), $urandom);
    end

    for (int i = 0; i < 64; i++) check("final_mem", mem_arr[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
